axis_coincidence_reader: RTL and testbench

Parametrised multi-channel coincidence detector for the detector readout chain. Watches a bank of CHANNELS hit buses, opens a programmable coincidence window on the first hit, and ORs all hits seen in that window. It counts how many channels fired and emits one AXI4-Stream word holding the first-hit timestamp and the accumulated hit pattern when the multiplicity reaches a threshold. It adds tready backpressure, a one-deep output slot and a saturating lost-event counter, and sits between the detector front-end sampling and the DMA/FIFO writer.

---
 rtl/axis_coincidence_reader_if.sv | 11 +
 rtl/axis_coincidence_reader.sv | 176 +++++++++++++++++
 tb/tb_axis_coincidence_reader.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/axis_coincidence_reader_if.sv
// AXI4-Stream output bus of the coincidence reader: one event word per transfer.
interface axis_coincidence_reader_if #(
  parameter int DATA_W = 158
);
  logic [DATA_W-1:0] tdata;
  logic              tvalid;
  logic              tready;

  modport master (output tdata, output tvalid, input tready);
  modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/axis_coincidence_reader.sv
// Multi-channel coincidence window with multiplicity threshold and AXIS event output.
// Optional COINCIDENCE_READER_MASK_EN adds cfg_mask (per-channel trigger/multiplicity enable).
module axis_coincidence_lane #(
  parameter int CHANNEL_WIDTH = 16
) (
  input  logic                     aclk,
  input  logic                     aresetn,
  input  logic [CHANNEL_WIDTH-1:0] din,
  input  logic                     en,
  input  logic                     capture,
  input  logic                     accum,
  input  logic                     reduce,
  output logic                     hit,
  output logic [CHANNEL_WIDTH-1:0] data,
  output logic                     flag
);
  logic [CHANNEL_WIDTH-1:0] data_q, data_d;
  logic                     flag_q, flag_d;

  // Masked lanes still contribute hit bits to the pattern, just not to trigger/multiplicity.
  assign hit  = en & (|din);
  assign data = data_q;
  assign flag = flag_q;

  always_comb begin
    data_d = data_q;
    flag_d = flag_q;
    if (capture)     data_d = din;
    else if (accum)  data_d = data_q | din;
    if (reduce)      flag_d = en & (|data_q);
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      data_q <= '0;
      flag_q <= 1'b0;
    end else begin
      data_q <= data_d;
      flag_q <= flag_d;
    end
  end
endmodule

module axis_coincidence_reader #(
  parameter  int CHANNELS      = 6,
  parameter  int CHANNEL_WIDTH = 16,
  parameter  int TIME_WIDTH    = 62,
  parameter  int CNTR_WIDTH    = 8,
  parameter  int LOST_WIDTH    = 32,
  localparam int SUM_WIDTH     = $clog2(CHANNELS+1),
  localparam int DATA_WIDTH    = CHANNELS*CHANNEL_WIDTH
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic [CNTR_WIDTH-1:0] cfg_window,
  input  logic [SUM_WIDTH-1:0]  cfg_threshold,
`ifdef COINCIDENCE_READER_MASK_EN
  input  logic [CHANNELS-1:0]   cfg_mask,
`endif
  axis_coincidence_reader_if.master m_axis,
  output logic [LOST_WIDTH-1:0] lost_count
);
  typedef enum logic [2:0] {IDLE, COLLECT, REDUCE, COUNT, DECIDE} state_t;

  state_t                                     state_q, state_d;
  logic [TIME_WIDTH-1:0]                      ts_q, ts_d;
  logic [TIME_WIDTH-1:0]                      time_q, time_d;
  logic [CNTR_WIDTH-1:0]                      cntr_q, cntr_d;
  logic [SUM_WIDTH-1:0]                       sum_q, sum_d;
  logic [TIME_WIDTH+DATA_WIDTH-1:0]           tdata_q, tdata_d;
  logic                                       tvalid_q, tvalid_d;
  logic [LOST_WIDTH-1:0]                      lost_q, lost_d;

  logic [CHANNELS-1:0]                        ch_en, lane_hit, lane_flag;
  logic [CHANNELS-1:0][CHANNEL_WIDTH-1:0]     lane_data;
  logic [DATA_WIDTH-1:0]                      data_flat;
  logic                                       trig, capture, accum, reduce;

`ifdef COINCIDENCE_READER_MASK_EN
  assign ch_en = cfg_mask;
`else
  assign ch_en = '1;
`endif

  assign trig      = |lane_hit;
  assign capture   = (state_q == IDLE) && trig;
  assign accum     = (state_q == COLLECT);
  assign reduce    = (state_q == REDUCE);
  assign data_flat = lane_data;

  for (genvar k = 0; k < CHANNELS; k++) begin : g_lane
    axis_coincidence_lane #(.CHANNEL_WIDTH(CHANNEL_WIDTH)) u_lane (
      .aclk    (aclk),
      .aresetn (aresetn),
      .din     (din[k*CHANNEL_WIDTH +: CHANNEL_WIDTH]),
      .en      (ch_en[k]),
      .capture (capture),
      .accum   (accum),
      .reduce  (reduce),
      .hit     (lane_hit[k]),
      .data    (lane_data[k]),
      .flag    (lane_flag[k])
    );
  end

  always_comb begin
    state_d  = state_q;
    ts_d     = ts_q + TIME_WIDTH'(1);
    time_d   = time_q;
    cntr_d   = cntr_q;
    sum_d    = sum_q;
    tdata_d  = tdata_q;
    tvalid_d = tvalid_q;
    lost_d   = lost_q;

    if (tvalid_q && m_axis.tready) tvalid_d = 1'b0;

    unique case (state_q)
      IDLE: if (trig) begin
        time_d  = ts_q;
        cntr_d  = '0;
        state_d = COLLECT;
      end
      COLLECT: begin
        cntr_d = cntr_q + CNTR_WIDTH'(1);
        // A shrinking cfg_window mid-window just ends collection early; never stalls.
        if (cntr_q >= cfg_window) state_d = REDUCE;
      end
      REDUCE: state_d = COUNT;
      COUNT: begin
        sum_d = '0;
        for (int k = 0; k < CHANNELS; k++) sum_d = sum_d + SUM_WIDTH'(lane_flag[k]);
        state_d = DECIDE;
      end
      DECIDE: begin
        state_d = IDLE;
        if (sum_q >= cfg_threshold) begin
          if (!tvalid_q || m_axis.tready) begin
            tdata_d  = {time_q, data_flat};
            tvalid_d = 1'b1;
          end else if (lost_q != '1) begin
            lost_d = lost_q + LOST_WIDTH'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q  <= IDLE;
      ts_q     <= '0;
      time_q   <= '0;
      cntr_q   <= '0;
      sum_q    <= '0;
      tdata_q  <= '0;
      tvalid_q <= 1'b0;
      lost_q   <= '0;
    end else begin
      state_q  <= state_d;
      ts_q     <= ts_d;
      time_q   <= time_d;
      cntr_q   <= cntr_d;
      sum_q    <= sum_d;
      tdata_q  <= tdata_d;
      tvalid_q <= tvalid_d;
      lost_q   <= lost_d;
    end
  end

  assign m_axis.tdata  = tdata_q;
  assign m_axis.tvalid = tvalid_q;
  assign lost_count    = lost_q;
endmodule

// File: tb/tb_axis_coincidence_reader.sv
// Directed bench for axis_coincidence_reader; expected words are queued and checked on handshake.
module tb_axis_coincidence_reader;
  localparam int DW = 62 + 96;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic [95:0] din;
  logic [7:0]  cfg_window;
  logic [2:0]  cfg_threshold;
  logic [31:0] lost_count;
`ifdef COINCIDENCE_READER_MASK_EN
  logic [5:0]  cfg_mask;
`endif

  axis_coincidence_reader_if #(.DATA_W(DW)) m_axis ();

  axis_coincidence_reader dut (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .din           (din),
    .cfg_window    (cfg_window),
    .cfg_threshold (cfg_threshold),
`ifdef COINCIDENCE_READER_MASK_EN
    .cfg_mask      (cfg_mask),
`endif
    .m_axis        (m_axis.master),
    .lost_count    (lost_count)
  );

  always #5 aclk = ~aclk;

  int total = 0;
  int bad   = 0;
  logic [DW-1:0] exp_q[$];
  logic [61:0]   ts_m;

  // Reference timestamp: counts edges since the last reset edge.
  always @(posedge aclk) ts_m <= aresetn ? ts_m + 62'd1 : 62'd0;

  task automatic tick();
    @(posedge aclk); #1;
  endtask

  task automatic chk_vec(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic chk_int(input string nm, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  // Scoreboard monitor
  always @(negedge aclk) begin
    if (aresetn && m_axis.tvalid && m_axis.tready) begin
      if (exp_q.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_word: got %h want none", m_axis.tdata);
      end else begin
        chk_vec("word", m_axis.tdata, exp_q.pop_front());
      end
    end
  end

  task automatic wait_valid(input string nm, input int exp_lat, input int start);
    int n = start;
    while (!m_axis.tvalid && n < 40) begin
      tick();
      n++;
    end
    chk_int(nm, n, exp_lat);
  endtask

  task automatic fire(input logic [95:0] v, input bit push);
    if (push) exp_q.push_back({ts_m, v});
    din = v;
    tick();
    din = '0;
    repeat (int'(cfg_window) + 4) tick();
  endtask

  initial begin
    logic [95:0]   pat;
    logic [DW-1:0] w1;
    bit            seen;

    aresetn = 1'b0; din = '0; cfg_window = 8'd3; cfg_threshold = 3'd2;
    m_axis.tready = 1'b1;
`ifdef COINCIDENCE_READER_MASK_EN
    cfg_mask = 6'b111111;
`endif
    repeat (3) tick();
    aresetn = 1'b1;
    chk_int("rst_tvalid", m_axis.tvalid, 0);
    chk_vec("rst_tdata", m_axis.tdata, '0);
    chk_int("rst_lost", lost_count, 0);
    repeat (2) tick();

    // ch0 trigger, ch3 bit5 two cycles later
    pat = (96'd1 << 53) | 96'd1;
    exp_q.push_back({ts_m, pat});
    din = 96'd1; tick();
    din = '0;    tick();
    din = 96'd1 << 53; tick();
    din = '0;
    wait_valid("latency_w3", 8, 3);
    tick();
    chk_int("lost_after_basic", lost_count, 0);
    repeat (2) tick();

    // single channel under threshold 3, then a retrigger right at T+8
    cfg_threshold = 3'd3;
    seen = 0;
    din = 96'd1 << 16;
    for (int i = 0; i < 8; i++) begin
      if (i == 5) din = '0;
      if (m_axis.tvalid) seen = 1;
      tick();
    end
    chk_int("thr_reject", seen, 0);
    pat = (96'd1 << 32) | (96'd1 << 16) | 96'd1;
    exp_q.push_back({ts_m, pat});
    din = pat; tick();
    din = '0;
    wait_valid("idle_after_reject", 8, 1);
    repeat (3) tick();

    // backpressure: one held word, two lost
    cfg_threshold = 3'd1;
    m_axis.tready = 1'b0;
    w1 = {ts_m, 96'd1 << 32};
    fire(96'd1 << 32, 1'b1);
    fire(96'd1 << 33, 1'b0);
    fire(96'd1 << 34, 1'b0);
    chk_int("lost_two", lost_count, 2);
    chk_int("held_valid", m_axis.tvalid, 1);
    chk_vec("held_tdata", m_axis.tdata, w1);
    m_axis.tready = 1'b1; tick();
    m_axis.tready = 1'b0;
    chk_int("drop_after_accept", m_axis.tvalid, 0);
    repeat (2) tick();

    // DECIDE coincides with handshake of the held word
    fire(96'd1 << 48, 1'b1);
    pat = 96'd1 << 64;
    w1 = {ts_m, pat};
    exp_q.push_back(w1);
    din = pat; tick();
    din = '0;
    repeat (6) tick();
    m_axis.tready = 1'b1; tick();
    m_axis.tready = 1'b0;
    chk_int("reload_valid", m_axis.tvalid, 1);
    chk_vec("reload_tdata", m_axis.tdata, w1);
    chk_int("reload_lost", lost_count, 2);
    m_axis.tready = 1'b1;
    repeat (2) tick();

    // reset with a pending word and an open window
    m_axis.tready = 1'b0;
    fire(96'd1 << 70, 1'b0);
    din = 96'd1 << 71; tick();
    din = '0; tick();
    aresetn = 1'b0; tick();
    aresetn = 1'b1;
    chk_int("midrst_tvalid", m_axis.tvalid, 0);
    chk_vec("midrst_tdata", m_axis.tdata, '0);
    chk_int("midrst_lost", lost_count, 0);
    m_axis.tready = 1'b1;
    repeat (4) tick();
    pat = 96'd1 << 79;
    exp_q.push_back({62'd4, pat});
    din = pat; tick();
    din = '0;
    wait_valid("post_rst_latency", 8, 1);
    repeat (2) tick();

    // zero-length window and zero threshold
    cfg_window = 8'd0; cfg_threshold = 3'd0;
    pat = 96'd1 << 80;
    exp_q.push_back({ts_m, pat});
    din = pat; tick();
    din = '0;
    wait_valid("latency_w0", 5, 1);
    repeat (2) tick();

`ifdef COINCIDENCE_READER_MASK_EN
    cfg_window = 8'd3; cfg_threshold = 3'd2; cfg_mask = 6'b111110;
    seen = 0;
    din = 96'd1;
    for (int i = 0; i < 14; i++) begin
      if (i == 6) din = '0;
      if (m_axis.tvalid) seen = 1;
      tick();
    end
    chk_int("mask_no_trigger", seen, 0);
    seen = 0;
    din = (96'd1 << 16) | 96'd1; tick();
    din = '0;
    for (int i = 0; i < 12; i++) begin
      if (m_axis.tvalid) seen = 1;
      tick();
    end
    chk_int("mask_sum_reject", seen, 0);
    cfg_mask = 6'b111111;
`endif

    repeat (5) tick();
    chk_int("queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
